saa5050_glyph_fetch: RTL and testbench
======================================

// Module: saa5050_glyph_fetch
// PURPOSE
//  Read-side initiator for the SAA5050 character ROM. Accepts one character per valid/ready
//  handshake and issues the ROM address. It absorbs the ROM's one-cycle address latch,
//  buffers one glyph row, and shifts GLYPH_W pixels out MSB-first on each pixel_en tick.
//  It sits between the teletext row/attribute logic and the video mux.
// PARAMETERS
//  CODE_BITS  7  character code width
//  ROW_BITS   4  glyph scan-row width
//  GLYPH_W    6  pixels per glyph row, taken from rom_q[GLYPH_W-1:0] (bit GLYPH_W-1 leftmost)
//  MEM_BITS   localparam = 1+CODE_BITS+ROW_BITS (12), must match the ROM address width
// PORTS
//  clock        in   1          single system clock, all logic on posedge
//  reset        in   1          synchronous, active-high
//  flush        in   1          synchronous clear of pipeline (line start), same effect as reset
//  pixel_en     in   1          pixel-rate enable
//  char_valid   in   1          char_code/char_row/char_alt valid
//  char_ready   out  1          block can accept a character this cycle
//  char_code    in   CODE_BITS  character code
//  char_row     in   ROW_BITS   scan row within the glyph
//  char_alt     in   1          bank select, becomes the address MSB
//  rom_address  out  MEM_BITS   registered ROM address {char_alt,char_code,char_row}
//  rom_q        in   8          ROM data; valid the cycle after the ROM latches rom_address
//  pixel_out    out  1          current pixel
//  pixel_valid  out  1          pixel_out carries glyph data
//  glyph_first  out  1          one-clock pulse with the leftmost pixel of each glyph
// BEHAVIOUR
//  Reset/flush: fetch FSM to F_IDLE, buf_full=0, shift count=0.
//   pixel_out=0, pixel_valid=0, glyph_first=0, rom_address=0.
//   Any in-flight fetch is discarded. reset has priority over flush; flush over all else.
//  Fetch FSM (advances every clock, independent of pixel_en):
//   F_IDLE: char_ready = (buf_full==0). On valid&&ready: load rom_address, go to F_ADDR.
//   F_ADDR: the ROM latches rom_address at this edge. Go to F_DATA.
//   F_DATA: buf <= rom_q[GLYPH_W-1:0], buf_full <= 1. Go to F_IDLE.
//   char_ready is 0 in F_ADDR and F_DATA. rom_address holds its value outside accepts.
//  Latency: accept at edge N, buffer written at edge N+2.
//   The first pixel can appear on the first pixel_en at or after edge N+3.
//  Shifter (updates only when pixel_en=1; outputs hold otherwise):
//   cnt>0: shift left, pixel_out <= next bit, cnt <= cnt-1, pixel_valid=1, glyph_first=0.
//   cnt==0 and buf_full: load from buf, pixel_out <= buf[GLYPH_W-1], cnt <= GLYPH_W-1,
//    buf_full <= 0, pixel_valid=1, glyph_first=1.
//   cnt==0 and !buf_full (underrun): pixel_out=0, pixel_valid=0, glyph_first=0.
//  glyph_first is deasserted on the clock after its pixel_en, so it is a single-clock pulse.
//  Simultaneous: shifter load from buf and F_DATA write cannot collide (accept needs
//   buf_full==0). A buf_full clear and a new accept may occur on consecutive clocks.
//  Throughput: with pixel_en every clock, a refill (3 clocks) is shorter than GLYPH_W
//   ticks. A source that presents a char whenever char_ready is high gives gap-free pixels.
//  rom_q bits above GLYPH_W-1 are ignored. All counters are $clog2(GLYPH_W) bits, no wrap use.
// STRUCTURE
//  Shared package: fetch FSM state enum (F_IDLE, F_ADDR, F_DATA).
//   Also CODE_BITS, ROW_BITS and GLYPH_W defaults, shared with the row/attribute logic.
//  One natural sub-module: saa5050_glyph_shifter (buf + shift register + cnt).
//   Its interface is a load strobe, data, pixel_en and a buf_full flag.
//  The fetch FSM stays in the top. The ROM itself is instantiated outside this block.
// TESTING (bench instantiates the real ROM model with a known mif)
//  1 Single char alt=0 code=0x41 row=3 -> rom_address=0x413 one clock after accept.
//    Buffer written 2 clocks after accept. 6 pixels match mif[0x413][5:0] MSB-first.
//    glyph_first on the first pixel only.
//  2 Back-to-back chars, pixel_en=1 every clock, source always valid -> pixel_valid held
//    high, no gaps across 8 glyphs. char_ready low exactly in F_ADDR/F_DATA or while buf_full.
//  3 pixel_en 1-in-3 -> outputs hold between ticks. Exactly 6 ticks per glyph.
//    Fetch timing unchanged.
//  4 Source starves after one char -> after its 6th pixel, pixel_valid=0, pixel_out=0 until
//    the next char's data is loaded.
//  5 flush asserted in F_ADDR -> discarded fetch produces no pixels. char_ready=1 next clock.
//    The next char fetches normally.
//  6 reset mid-glyph (cnt=3) -> all outputs 0 next clock. Resuming gives a fresh glyph_first.
//    Same for alt=1 code=0x7F row=0xF -> rom_address=0xFFF.

Source files
------------

// File: rtl/saa5050_glyph_fetch_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | saa5050_glyph_fetch_pkg                                                  |
// | Shared widths and fetch FSM encoding for the SAA5050 glyph path.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package saa5050_glyph_fetch_pkg;

  // Defaults shared with the teletext row/attribute logic
  localparam int C_CODE_BITS = 7;
  localparam int C_ROW_BITS  = 4;
  localparam int C_GLYPH_W   = 6;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_ADDR = 2'd1,
    F_DATA = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/saa5050_glyph_shifter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | saa5050_glyph_shifter                                                    |
// | One-row glyph buffer feeding an MSB-first pixel shifter on pixel_en.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module saa5050_glyph_shifter
  import saa5050_glyph_fetch_pkg::*;
#(
  parameter int GLYPH_W = C_GLYPH_W
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               pixel_en,
  input  logic               load,
  input  logic [GLYPH_W-1:0] load_data,
  output logic               buf_full,
  output logic               pixel_out,
  output logic               pixel_valid,
  output logic               glyph_first
);

  localparam int C_CNT_W = $clog2(GLYPH_W);

  logic [GLYPH_W-1:0] r_buf;
  // The leftmost pixel goes straight to pixel_out, so only the remaining bits are shifted
  logic [GLYPH_W-2:0] r_shift;
  logic [C_CNT_W-1:0] r_cnt;
  logic               r_buf_full;
  logic               r_pixel_out;
  logic               r_pixel_valid;
  logic               r_glyph_first;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_buf         <= '0;
      r_shift       <= '0;
      r_cnt         <= '0;
      r_buf_full    <= 1'b0;
      r_pixel_out   <= 1'b0;
      r_pixel_valid <= 1'b0;
      r_glyph_first <= 1'b0;
    end else begin
      if (pixel_en) begin
        if (r_cnt != '0) begin
          r_pixel_out   <= r_shift[GLYPH_W-2];
          r_shift       <= {r_shift[GLYPH_W-3:0], 1'b0};
          r_cnt         <= r_cnt - C_CNT_W'(1);
          r_pixel_valid <= 1'b1;
          r_glyph_first <= 1'b0;
        end else if (r_buf_full) begin
          r_pixel_out   <= r_buf[GLYPH_W-1];
          r_shift       <= r_buf[GLYPH_W-2:0];
          r_cnt         <= C_CNT_W'(GLYPH_W-1);
          r_buf_full    <= 1'b0;
          r_pixel_valid <= 1'b1;
          r_glyph_first <= 1'b1;
        end else begin
          r_pixel_out   <= 1'b0;
          r_pixel_valid <= 1'b0;
          r_glyph_first <= 1'b0;
        end
      end else begin
        r_glyph_first <= 1'b0;
      end
      // A write only happens after an accept, which required an empty buffer
      if (load) begin
        r_buf      <= load_data;
        r_buf_full <= 1'b1;
      end
    end
  end

  assign buf_full    = r_buf_full;
  assign pixel_out   = r_pixel_out;
  assign pixel_valid = r_pixel_valid;
  assign glyph_first = r_glyph_first;

endmodule
`default_nettype wire

// File: rtl/saa5050_glyph_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | saa5050_glyph_fetch                                                      |
// | Character ROM read initiator: fetch FSM, ROM address register, shifter.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module saa5050_glyph_fetch
  import saa5050_glyph_fetch_pkg::*;
#(
  parameter int CODE_BITS = C_CODE_BITS,
  parameter int ROW_BITS  = C_ROW_BITS,
  parameter int GLYPH_W   = C_GLYPH_W
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            flush,
  input  logic                            pixel_en,
  input  logic                            char_valid,
  output logic                            char_ready,
  input  logic [CODE_BITS-1:0]            char_code,
  input  logic [ROW_BITS-1:0]             char_row,
  input  logic                            char_alt,
  output logic [1+CODE_BITS+ROW_BITS-1:0] rom_address,
  input  logic [7:0]                      rom_q,
  output logic                            pixel_out,
  output logic                            pixel_valid,
  output logic                            glyph_first
);

  localparam int MEM_BITS = 1 + CODE_BITS + ROW_BITS;

  fetch_state_t        r_state;
  fetch_state_t        w_state_next;
  logic [MEM_BITS-1:0] r_rom_address;
  logic                w_clear;
  logic                w_accept;
  logic                w_buf_load;
  logic                w_buf_full;

  assign w_clear = reset | flush;

  always_ff @(posedge clock) begin
    if (w_clear) begin
      r_state <= F_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // F_ADDR is the ROM's address-latch cycle; data is only valid in F_DATA
  always_comb begin
    w_state_next = r_state;
    char_ready   = 1'b0;
    w_accept     = 1'b0;
    w_buf_load   = 1'b0;
    case (r_state)
      F_IDLE: begin
        char_ready = ~w_buf_full;
        if (char_valid && !w_buf_full) begin
          w_accept     = 1'b1;
          w_state_next = F_ADDR;
        end
      end
      F_ADDR: begin
        w_state_next = F_DATA;
      end
      F_DATA: begin
        w_buf_load   = 1'b1;
        w_state_next = F_IDLE;
      end
      default: begin
        w_state_next = F_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (w_clear) begin
      r_rom_address <= '0;
    end else if (w_accept) begin
      r_rom_address <= {char_alt, char_code, char_row};
    end
  end

  assign rom_address = r_rom_address;

  generate
    if (GLYPH_W < 8) begin : g_rom_unused
      logic w_unused_rom_bits;
      assign w_unused_rom_bits = &{1'b0, rom_q[7:GLYPH_W]};
    end
  endgenerate

  saa5050_glyph_shifter #(
    .GLYPH_W (GLYPH_W)
  ) u_shifter (
    .clock       (clock),
    .clear       (w_clear),
    .pixel_en    (pixel_en),
    .load        (w_buf_load),
    .load_data   (rom_q[GLYPH_W-1:0]),
    .buf_full    (w_buf_full),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .glyph_first (glyph_first)
  );

endmodule
`default_nettype wire

// File: tb/tb_saa5050_glyph_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_saa5050_glyph_fetch                                                   |
// | Randomized bench with a transaction-level pixel-stream reference model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_saa5050_glyph_fetch;

  localparam int GW = 6;

  logic        clock = 1'b0;
  logic        reset, flush, pixel_en, char_valid, char_alt;
  logic        char_ready, pixel_out, pixel_valid, glyph_first;
  logic [6:0]  char_code;
  logic [3:0]  char_row;
  logic [11:0] rom_address;
  logic [7:0]  rom_q;

  logic [7:0]  mem [0:4095];

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: fetch countdown to buffer write, buffered row, pending pixels
  int          m_busy;
  bit          m_full;
  bit [GW-1:0] m_data;
  bit          m_bits[$];
  bit          m_out, m_valid, m_first;
  bit [11:0]   m_addr;

  int gaps, seen_valid, firsts;

  always #5 clock = ~clock;

  always @(posedge clock) rom_q <= mem[rom_address];

  saa5050_glyph_fetch dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .pixel_en    (pixel_en),
    .char_valid  (char_valid),
    .char_ready  (char_ready),
    .char_code   (char_code),
    .char_row    (char_row),
    .char_alt    (char_alt),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .glyph_first (glyph_first)
  );

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit         ready_pre;
    logic [7:0] word;
    ready_pre = (m_busy == 0) && !m_full;
    if (reset || flush) begin
      m_busy = 0; m_full = 0; m_bits.delete();
      m_out = 0; m_valid = 0; m_first = 0; m_addr = '0;
    end else begin
      if (pixel_en) begin
        if (m_bits.size() > 0) begin
          m_out = m_bits.pop_front(); m_valid = 1; m_first = 0;
        end else if (m_full) begin
          for (int i = GW - 1; i >= 0; i--) m_bits.push_back(m_data[i]);
          m_out = m_bits.pop_front(); m_valid = 1; m_first = 1; m_full = 0;
        end else begin
          m_out = 0; m_valid = 0; m_first = 0;
        end
      end else begin
        m_first = 0;
      end
      // Accept at edge N: ROM latches at N+1, buffer written at N+2
      if (m_busy == 2) begin
        m_busy = 1;
      end else if (m_busy == 1) begin
        word = mem[m_addr];
        m_data = word[GW-1:0];
        m_full = 1;
        m_busy = 0;
      end else if (char_valid && ready_pre) begin
        m_busy = 2;
        m_addr = {char_alt, char_code, char_row};
      end
    end
  endtask

  task automatic compare_all();
    check("addr",  rom_address, m_addr);
    check("ready", char_ready, ((m_busy == 0) && !m_full) ? 1 : 0);
    check("valid", pixel_valid, m_valid);
    check("pixel", pixel_out, m_out);
    check("first", glyph_first, m_first);
    if (pixel_valid) seen_valid = 1;
    else if (seen_valid != 0) gaps++;
    if (glyph_first) firsts++;
  endtask

  task automatic step(input bit rst, input bit fl, input bit pen, input bit v,
                      input logic [6:0] code, input logic [3:0] row, input bit alt);
    reset = rst; flush = fl; pixel_en = pen; char_valid = v;
    char_code = code; char_row = row; char_alt = alt;
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input bit pen);
    for (int i = 0; i < n; i++) step(0, 0, pen, 0, 7'h00, 4'h0, 0);
  endtask

  initial begin
    logic [7:0] w;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[12'h413] = 8'h2D;
    m_busy = 0; m_full = 0; m_out = 0; m_valid = 0; m_first = 0; m_addr = '0;
    gaps = 0; seen_valid = 0; firsts = 0;

    // Reset state
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 7'h00, 4'h0, 0);
    check("rst_ready", char_ready, 1);
    check("rst_addr", rom_address, 0);

    // Single character, one-clock address latency, pixels MSB-first
    step(0, 0, 1, 1, 7'h41, 4'h3, 0);
    check("t1_addr", rom_address, 12'h413);
    idle(3, 1);
    w = mem[12'h413];
    check("t1_first_pix", pixel_out, w[GW-1]);
    check("t1_first_flag", glyph_first, 1);
    idle(10, 1);

    // Back-to-back source, pixel_en every clock: no gaps
    gaps = 0; seen_valid = 0; firsts = 0;
    for (int i = 0; i < 80; i++)
      step(0, 0, 1, 1, 7'($urandom), 4'($urandom), 1'($urandom));
    check("t2_gaps", gaps, 0);
    check("t2_enough_glyphs", (firsts >= 8) ? 1 : 0, 1);

    // pixel_en one clock in three
    for (int i = 0; i < 150; i++)
      step(0, 0, (i % 3) == 0, 1'($urandom), 7'($urandom), 4'($urandom), 1'($urandom));

    // Starve after one character
    step(0, 1, 0, 0, 7'h00, 4'h0, 0);
    step(0, 0, 1, 1, 7'($urandom), 4'($urandom), 0);
    idle(20, 1);
    check("t4_idle_valid", pixel_valid, 0);
    check("t4_idle_pixel", pixel_out, 0);

    // Flush while in the address-latch cycle
    step(0, 0, 1, 1, 7'h12, 4'h5, 0);
    step(0, 1, 1, 0, 7'h00, 4'h0, 0);
    check("t5_ready", char_ready, 1);
    firsts = 0;
    idle(8, 1);
    check("t5_no_pixels", firsts, 0);
    step(0, 0, 1, 1, 7'h22, 4'h1, 1);
    idle(10, 1);
    check("t5_refetch", firsts, 1);

    // Reset mid-glyph, then a fresh glyph at the top address
    step(0, 0, 1, 1, 7'h33, 4'h7, 0);
    idle(5, 1);
    step(1, 0, 1, 0, 7'h00, 4'h0, 0);
    check("t6_valid", pixel_valid, 0);
    check("t6_pixel", pixel_out, 0);
    check("t6_first", glyph_first, 0);
    check("t6_addr0", rom_address, 0);
    firsts = 0;
    step(0, 0, 1, 1, 7'h7F, 4'hF, 1);
    check("t6_addr", rom_address, 12'hFFF);
    idle(10, 1);
    check("t6_fresh_first", firsts, 1);

    // Random mix including occasional flush and reset
    for (int i = 0; i < 500; i++)
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0), 1'($urandom),
           ($urandom_range(0, 9) < 7), 7'($urandom), 4'($urandom), 1'($urandom));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
